// File: rtl/fifo_protocol_monitor.sv
// fifo_protocol_monitor: passive protocol checker for NUM_CH synchronous FIFOs.
// It keeps a shadow occupancy per channel and flags push-while-full,
// pop-while-empty and full/empty flag inconsistencies. Violations are recorded
// in sticky flags, a saturating counter and a first-error capture register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, pop         per-channel push/pop strobes observed at the FIFO
//   full, empty       per-channel status flags reported by the FIFO
//   clear             synchronous clear of all error state (occupancy kept)
//   occ_sel, occ_out  combinational read of one channel's shadow occupancy
//   err_type_sticky   per-code sticky OR across channels
//                     {empty_mismatch, full_mismatch, pop_empty, push_full}
//   err_chan_sticky   per-channel sticky violation flag
//   viol_count        saturating total violation count
//   first_err_*       capture of the first violation (channel, code)
//   err_irq           one-cycle pulse when a capture is taken
module fifo_protocol_monitor #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PASSTHRU = 1,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] push,
  input  logic [NUM_CH-1:0] pop,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic              clear,
  input  logic [SEL_W-1:0]  occ_sel,
  output logic [OCC_W-1:0]  occ_out,
  output logic [3:0]        err_type_sticky,
  output logic [NUM_CH-1:0] err_chan_sticky,
  output logic [CNT_W-1:0]  viol_count,
  output logic              first_err_valid,
  output logic [SEL_W-1:0]  first_err_chan,
  output logic [1:0]        first_err_code,
  output logic              err_irq
);

  localparam int unsigned V_W   = $clog2(4 * NUM_CH + 1);
  localparam int unsigned SUM_W = CNT_W + V_W;
  localparam logic        PT    = (PASSTHRU != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OCC_W-1:0]  occ_q [NUM_CH];
  logic [OCC_W-1:0]  occ_d [NUM_CH];
  logic [3:0]        viol  [NUM_CH];
  logic [NUM_CH-1:0] at_full, at_empty, inc, dec;

  logic [V_W-1:0]    v_cnt;
  logic [3:0]        v_type;
  logic [NUM_CH-1:0] v_chan;
  logic              win_found;
  logic [SEL_W-1:0]  win_chan;
  logic [1:0]        win_code;

  logic [CNT_W-1:0]  base_cnt;
  logic              base_valid;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_d;
  logic              capture;

  // Per-channel checks and shadow occupancy update (clamped, never wraps).
  always_comb begin
    at_full  = '0;
    at_empty = '0;
    inc      = '0;
    dec      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      at_full[i]  = (occ_q[i] == OCC_W'(DEPTH));
      at_empty[i] = (occ_q[i] == '0);
      viol[i][0]  = push[i] & full[i] & ~(PT & pop[i]);
      viol[i][1]  = pop[i] & empty[i];
      viol[i][2]  = full[i] != at_full[i];
      viol[i][3]  = empty[i] != at_empty[i];
      inc[i]      = push[i] & (~full[i] | (PT & pop[i]));
      // The shadow count must be nonzero too, so it can never underflow.
      dec[i]      = pop[i] & ~empty[i] & ~at_empty[i];
      occ_d[i]    = occ_q[i];
      if (inc[i] && !dec[i] && !at_full[i]) begin
        occ_d[i] = occ_q[i] + OCC_W'(1);
      end else if (dec[i] && !inc[i]) begin
        occ_d[i] = occ_q[i] - OCC_W'(1);
      end
    end
  end

  // Violation tally and first-error priority: lowest channel, then lowest code.
  always_comb begin
    v_cnt     = '0;
    v_type    = '0;
    v_chan    = '0;
    win_found = 1'b0;
    win_chan  = '0;
    win_code  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (viol[i][c]) begin
          v_cnt     = v_cnt + V_W'(1);
          v_type[c] = 1'b1;
          v_chan[i] = 1'b1;
          if (!win_found) begin
            win_found = 1'b1;
            win_chan  = SEL_W'(i);
            win_code  = 2'(c);
          end
        end
      end
    end
  end

  // A clear acts as if the error state were zero before this cycle's violations.
  always_comb begin
    base_cnt   = clear ? '0 : viol_count;
    base_valid = clear ? 1'b0 : first_err_valid;
    cnt_sum    = SUM_W'(base_cnt) + SUM_W'(v_cnt);
    cnt_d      = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    capture    = ~base_valid & win_found;
  end

  // Selected shadow occupancy; out-of-range selects read as zero.
  always_comb begin
    occ_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (occ_sel == SEL_W'(i)) occ_out = occ_q[i];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) occ_q[i] <= '0;
      err_type_sticky <= '0;
      err_chan_sticky <= '0;
      viol_count      <= '0;
      first_err_valid <= 1'b0;
      first_err_chan  <= '0;
      first_err_code  <= '0;
      err_irq         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) occ_q[i] <= occ_d[i];
      err_type_sticky <= (clear ? 4'b0 : err_type_sticky) | v_type;
      err_chan_sticky <= (clear ? '0 : err_chan_sticky) | v_chan;
      viol_count      <= cnt_d;
      err_irq         <= capture;
      if (capture) begin
        first_err_valid <= 1'b1;
        first_err_chan  <= win_chan;
        first_err_code  <= win_code;
      end else if (clear) begin
        first_err_valid <= 1'b0;
        first_err_chan  <= '0;
        first_err_code  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// tb_fifo_protocol_monitor: drives two monitors (PASSTHRU=1/CNT_W=4 and
// PASSTHRU=0/CNT_W=16, both NUM_CH=2, DEPTH=4) with shared directed and
// random stimulus. A rule-level reference model queues the expected outputs;
// a separate monitor process pops and compares them every cycle.
module tb_fifo_protocol_monitor;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] push, pop, full, empty;
  logic       clear;
  logic [0:0] occ_sel;

  logic [2:0]  occ_a, occ_b;
  logic [3:0]  type_a, type_b;
  logic [1:0]  chan_a, chan_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic        fv_a, fv_b;
  logic [0:0]  fch_a, fch_b;
  logic [1:0]  fcode_a, fcode_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  fifo_protocol_monitor #(.NUM_CH(2), .DEPTH(DEPTH), .CNT_W(4), .PASSTHRU(1)) dut_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .full(full), .empty(empty),
    .clear(clear), .occ_sel(occ_sel), .occ_out(occ_a), .err_type_sticky(type_a),
    .err_chan_sticky(chan_a), .viol_count(cnt_a), .first_err_valid(fv_a),
    .first_err_chan(fch_a), .first_err_code(fcode_a), .err_irq(irq_a));

  fifo_protocol_monitor #(.NUM_CH(2), .DEPTH(DEPTH), .CNT_W(16), .PASSTHRU(0)) dut_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .full(full), .empty(empty),
    .clear(clear), .occ_sel(occ_sel), .occ_out(occ_b), .err_type_sticky(type_b),
    .err_chan_sticky(chan_b), .viol_count(cnt_b), .first_err_valid(fv_b),
    .first_err_chan(fch_b), .first_err_code(fcode_b), .err_irq(irq_b));

  typedef struct {
    int occ_out; int typ; int chan; int cnt; int fv; int fch; int fcode; int irq;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int     m_occ [2][2];
  int     m_cnt [2];
  bit [3:0] m_type [2];
  bit [1:0] m_chan [2];
  bit     m_fv [2];
  int     m_fch [2];
  int     m_fcode [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_occ[d][0] = 0; m_occ[d][1] = 0;
      m_cnt[d] = 0; m_type[d] = '0; m_chan[d] = '0;
      m_fv[d] = 0; m_fch[d] = 0; m_fcode[d] = 0;
    end
  endfunction

  // One clock edge of monitor d, straight from the checking rules.
  function automatic exp_t model_step(int d, bit [1:0] pu, bit [1:0] po, bit [1:0] fu,
                                      bit [1:0] em, bit cl, int sel);
    exp_t e;
    bit [3:0] code;
    bit pt;
    int v, cmax, ep, epop;
    bit irq;
    pt   = (d == 0);
    cmax = (d == 0) ? 15 : 65535;
    if (cl) begin
      m_cnt[d] = 0; m_type[d] = '0; m_chan[d] = '0;
      m_fv[d] = 0; m_fch[d] = 0; m_fcode[d] = 0;
    end
    v = 0;
    irq = 0;
    for (int ch = 0; ch < 2; ch++) begin
      code[0] = pu[ch] && fu[ch] && !(pt && po[ch]);
      code[1] = po[ch] && em[ch];
      code[2] = fu[ch] != (m_occ[d][ch] == DEPTH);
      code[3] = em[ch] != (m_occ[d][ch] == 0);
      for (int c = 0; c < 4; c++) begin
        if (code[c]) begin
          v++;
          m_type[d][c] = 1'b1;
          m_chan[d][ch] = 1'b1;
          if (!m_fv[d]) begin
            m_fv[d] = 1; m_fch[d] = ch; m_fcode[d] = c; irq = 1;
          end
        end
      end
      ep   = (pu[ch] && (!fu[ch] || (pt && po[ch]))) ? 1 : 0;
      epop = (po[ch] && !em[ch] && m_occ[d][ch] != 0) ? 1 : 0;
      m_occ[d][ch] = m_occ[d][ch] + ep - epop;
      if (m_occ[d][ch] > DEPTH) m_occ[d][ch] = DEPTH;
      if (m_occ[d][ch] < 0) m_occ[d][ch] = 0;
    end
    m_cnt[d] = (m_cnt[d] + v > cmax) ? cmax : m_cnt[d] + v;
    e.occ_out = m_occ[d][sel];
    e.typ = int'(m_type[d]);
    e.chan = int'(m_chan[d]);
    e.cnt = m_cnt[d];
    e.fv = int'(m_fv[d]);
    e.fch = m_fch[d];
    e.fcode = m_fcode[d];
    e.irq = int'(irq);
    return e;
  endfunction

  task automatic drive(input bit [1:0] pu, input bit [1:0] po, input bit [1:0] fu,
                       input bit [1:0] em, input bit cl, input bit sel);
    @(negedge clk);
    push = pu; pop = po; full = fu; empty = em; clear = cl; occ_sel = sel;
    q_a.push_back(model_step(0, pu, po, fu, em, cl, int'(sel)));
    q_b.push_back(model_step(1, pu, po, fu, em, cl, int'(sel)));
  endtask

  // Flags that are correct for the PASSTHRU=1 monitor's shadow occupancy.
  task automatic drive_legal(input bit [1:0] pu, input bit [1:0] po, input bit cl,
                             input bit sel);
    bit [1:0] fu, em;
    for (int ch = 0; ch < 2; ch++) begin
      fu[ch] = (m_occ[0][ch] == DEPTH);
      em[ch] = (m_occ[0][ch] == 0);
    end
    drive(pu, po, fu, em, cl, sel);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, ".a.occ_out"}, int'(occ_a), 0);
    chk({tag, ".a.type"}, int'(type_a), 0);
    chk({tag, ".a.chan"}, int'(chan_a), 0);
    chk({tag, ".a.count"}, int'(cnt_a), 0);
    chk({tag, ".a.first_valid"}, int'(fv_a), 0);
    chk({tag, ".a.first_chan"}, int'(fch_a), 0);
    chk({tag, ".a.first_code"}, int'(fcode_a), 0);
    chk({tag, ".a.irq"}, int'(irq_a), 0);
    chk({tag, ".b.count"}, int'(cnt_b), 0);
    chk({tag, ".b.occ_out"}, int'(occ_b), 0);
    chk({tag, ".b.first_valid"}, int'(fv_b), 0);
    chk({tag, ".b.irq"}, int'(irq_b), 0);
  endtask

  // Monitor: compares registered outputs just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a.occ_out", int'(occ_a), e.occ_out);
        chk("a.type_sticky", int'(type_a), e.typ);
        chk("a.chan_sticky", int'(chan_a), e.chan);
        chk("a.viol_count", int'(cnt_a), e.cnt);
        chk("a.first_valid", int'(fv_a), e.fv);
        chk("a.first_chan", int'(fch_a), e.fch);
        chk("a.first_code", int'(fcode_a), e.fcode);
        chk("a.irq", int'(irq_a), e.irq);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b.occ_out", int'(occ_b), e.occ_out);
        chk("b.type_sticky", int'(type_b), e.typ);
        chk("b.chan_sticky", int'(chan_b), e.chan);
        chk("b.viol_count", int'(cnt_b), e.cnt);
        chk("b.first_valid", int'(fv_b), e.fv);
        chk("b.first_chan", int'(fch_b), e.fch);
        chk("b.first_code", int'(fcode_b), e.fcode);
        chk("b.irq", int'(irq_b), e.irq);
      end
    end
  end

  // Stimulus.
  initial begin
    bit [1:0] pu, po, fu, em;
    bit cl;
    rst = 1'b0; push = '0; pop = '0; full = '0; empty = 2'b11; clear = 1'b0; occ_sel = '0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    #20 rst = 1'b0;

    // Legal fill and drain of ch0.
    repeat (4) drive_legal(2'b01, 2'b00, 1'b0, 1'b0);
    repeat (4) drive_legal(2'b00, 2'b01, 1'b0, 1'b0);

    // ch0 to occ 1, then pop on a wrongly-empty ch0 plus wrong empty on ch1.
    drive_legal(2'b01, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("v3.count", int'(cnt_a), 3);
    chk("v3.first_chan", int'(fch_a), 0);
    chk("v3.first_code", int'(fcode_a), 1);
    chk("v3.chan_sticky", int'(chan_a), 3);

    // Fill ch1, then push into full ch1 (with a clear to start fresh).
    repeat (4) drive_legal(2'b10, 2'b00, 1'b0, 1'b1);
    drive_legal(2'b10, 2'b00, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("pf.count", int'(cnt_a), 1);
    chk("pf.first_chan", int'(fch_a), 1);
    chk("pf.first_code", int'(fcode_a), 0);
    chk("pf.type_sticky", int'(type_a), 1);
    chk("pf.irq", int'(irq_a), 1);
    chk("pf.occ_out", int'(occ_a), 4);

    // Fill ch0, then push&pop together while full.
    repeat (3) drive_legal(2'b01, 2'b00, 1'b0, 1'b0);
    drive_legal(2'b01, 2'b01, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("pt.a.count", int'(cnt_a), 0);
    chk("pt.a.occ_out", int'(occ_a), 4);
    chk("pt.b.count", int'(cnt_b), 1);
    chk("pt.b.first_code", int'(fcode_b), 0);

    // Counter saturation, then clear with one violation.
    repeat (20) drive_legal(2'b10, 2'b00, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("sat.count", int'(cnt_a), 15);
    drive_legal(2'b10, 2'b00, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("satclr.count", int'(cnt_a), 1);
    chk("satclr.irq", int'(irq_a), 1);
    chk("satclr.first_chan", int'(fch_a), 1);

    // Asynchronous reset with ch0 at occ 3.
    drive_legal(2'b00, 2'b01, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst.occ_out", int'(occ_a), 3);
    #1 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    push = '0; pop = '0; full = '0; empty = 2'b11; clear = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;

    // Random traffic, mostly correct flags with occasional corruption.
    for (int n = 0; n < 400; n++) begin
      pu = 2'($urandom);
      po = 2'($urandom);
      for (int ch = 0; ch < 2; ch++) begin
        fu[ch] = (m_occ[0][ch] == DEPTH);
        em[ch] = (m_occ[0][ch] == 0);
      end
      if ($urandom_range(7) == 0) fu = fu ^ 2'($urandom);
      if ($urandom_range(7) == 0) em = em ^ 2'($urandom);
      cl = ($urandom_range(15) == 0);
      drive(pu, po, fu, em, cl, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q_a.size() + q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
